// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate at the bounds, terminal-count and load-error pulses.
// Optional Gray-coded output is enabled by defining UDC_GRAY_OUT_EN.
module updown_mod_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SAT_MODE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             y,
   output logic             tc,
   output logic             load_err
`ifdef UDC_GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] gray
`endif
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);
   // One extra bit so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam logic             SAT     = (SAT_MODE != 0);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             load_err_q, load_err_d;
   logic             at_max, at_min, load_oor;

   assign at_max   = (count_q == MAX_VAL);
   assign at_min   = (count_q == '0);
   assign load_oor = ({1'b0, load_val} >= MOD_EXT);

   always_comb begin
      count_d    = count_q;
      tc_d       = 1'b0;
      load_err_d = 1'b0;
      if (sync_clr) begin
         count_d = '0;
      end else if (load) begin
         if (load_oor) begin
            count_d    = MAX_VAL;
            load_err_d = 1'b1;
         end else begin
            count_d = load_val;
         end
      end else if (en) begin
         if (!dir) begin
            if (at_max) begin
               // Saturated hold leaves count and tc untouched.
               if (!SAT) begin
                  count_d = '0;
                  tc_d    = 1'b1;
               end
            end else begin
               count_d = count_q + ONE_VAL;
               tc_d    = SAT && (count_q == (MAX_VAL - ONE_VAL));
            end
         end else begin
            if (at_min) begin
               if (!SAT) begin
                  count_d = MAX_VAL;
                  tc_d    = 1'b1;
               end
            end else begin
               count_d = count_q - ONE_VAL;
               tc_d    = SAT && (count_q == ONE_VAL);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         tc_q       <= tc_d;
         load_err_q <= load_err_d;
      end
   end

   assign count    = count_q;
   assign y        = count_q[WIDTH-1];
   assign tc       = tc_q;
   assign load_err = load_err_q;

`ifdef UDC_GRAY_OUT_EN
   assign gray = count_q ^ (count_q >> 1);
`endif

endmodule
